// File: rtl/prbs_pkg.sv
// Shared types and constants for the XNOR-feedback PRBS checker.
package prbs_pkg;

    typedef enum logic {
        SEARCH = 1'b0,
        CHECK  = 1'b1
    } state_t;

    // Default two-tap XNOR feedback positions (1-based) for the common PRBS orders.
    localparam int PRBS7_TAP_A  = 7;
    localparam int PRBS7_TAP_B  = 6;
    localparam int PRBS9_TAP_A  = 9;
    localparam int PRBS9_TAP_B  = 5;
    localparam int PRBS15_TAP_A = 15;
    localparam int PRBS15_TAP_B = 14;
    localparam int PRBS23_TAP_A = 23;
    localparam int PRBS23_TAP_B = 18;
    localparam int PRBS31_TAP_A = 31;
    localparam int PRBS31_TAP_B = 28;

    localparam int CNT_W = 32;

endpackage

// File: rtl/xnor_lfsr.sv
// Two-tap XNOR-feedback LFSR. It either shifts in an external bit (load_mode=1)
// or free-runs on its own prediction (load_mode=0).
module xnor_lfsr #(
    parameter int WIDTH = 7,
    parameter int TAP_A = 7,
    parameter int TAP_B = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step,
    input  logic             load_mode,
    input  logic             sin,
    output logic [WIDTH-1:0] state,
    output logic             pred
);

    assign pred = ~(state[TAP_A-1] ^ state[TAP_B-1]);

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= '0;
        end else if (step) begin
            state <= {state[WIDTH-2:0], load_mode ? sin : pred};
        end
    end

endmodule

// File: rtl/xnor_prbs_checker.sv
// Self-synchronising XNOR PRBS checker with a saturating bit-error counter.
// Define PRBS_CHK_BITCNT_EN to add the bit_cnt output (bits compared while locked).
module xnor_prbs_checker
    import prbs_pkg::*;
#(
    parameter int WIDTH    = 7,
    parameter int TAP_A    = PRBS7_TAP_A,
    parameter int TAP_B    = PRBS7_TAP_B,
    parameter int LOCK_CNT = 8,
    parameter int LOSS_CNT = 4,
    parameter int ERR_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             din,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             bit_err,
    output logic [ERR_W-1:0] err_cnt,
`ifdef PRBS_CHK_BITCNT_EN
    output logic [CNT_W-1:0] bit_cnt,
`endif
    output logic             sync_lost
);

    localparam int FILL_W  = $clog2(WIDTH + 1);
    localparam int MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int MISS_W  = $clog2(LOSS_CNT + 1);

    state_t             state_q, state_d;
    logic [FILL_W-1:0]  fill_cnt, fill_d;
    logic [MATCH_W-1:0] match_cnt, match_d;
    logic [MISS_W-1:0]  miss_cnt, miss_d;
    logic [WIDTH-1:0]   lfsr;
    logic               pred;
    logic               filled;
    logic               match;
    logic               chk_miss;
    logic               sync_lost_d;

    // Self-seeds from din while searching, free-runs on its own prediction once locked.
    xnor_lfsr #(
        .WIDTH (WIDTH),
        .TAP_A (TAP_A),
        .TAP_B (TAP_B)
    ) u_lfsr (
        .clk       (clk),
        .rst       (rst),
        .step      (en),
        .load_mode (state_q == SEARCH),
        .sin       (din),
        .state     (lfsr),
        .pred      (pred)
    );

    assign filled   = (fill_cnt == FILL_W'(WIDTH));
    assign match    = ~(din ^ pred);
    assign chk_miss = en && (state_q == CHECK) && !match;
    assign locked   = (state_q == CHECK);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        fill_d      = fill_cnt;
        match_d     = match_cnt;
        miss_d      = miss_cnt;
        sync_lost_d = 1'b0;
        if (en) begin
            case (state_q)
                SEARCH: begin
                    if (!filled) begin
                        fill_d = fill_cnt + 1'b1;
                    end else if (match && (lfsr != '1)) begin
                        // All-ones is the XNOR lock-up state and never counts as a match.
                        if (match_cnt == MATCH_W'(LOCK_CNT - 1)) begin
                            state_d = CHECK;
                            match_d = '0;
                            miss_d  = '0;
                        end else begin
                            match_d = match_cnt + 1'b1;
                        end
                    end else begin
                        match_d = '0;
                    end
                end
                CHECK: begin
                    if (match) begin
                        miss_d = '0;
                    end else if (miss_cnt == MISS_W'(LOSS_CNT - 1)) begin
                        state_d     = SEARCH;
                        fill_d      = '0;
                        match_d     = '0;
                        miss_d      = '0;
                        sync_lost_d = 1'b1;
                    end else begin
                        miss_d = miss_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= SEARCH;
            fill_cnt  <= '0;
            match_cnt <= '0;
            miss_cnt  <= '0;
            bit_err   <= 1'b0;
            sync_lost <= 1'b0;
            err_cnt   <= '0;
        end else begin
            state_q   <= state_d;
            fill_cnt  <= fill_d;
            match_cnt <= match_d;
            miss_cnt  <= miss_d;
            bit_err   <= chk_miss;
            sync_lost <= sync_lost_d;
            if (clr_cnt) begin
                err_cnt <= '0;
            end else if (chk_miss && (err_cnt != '1)) begin
                err_cnt <= err_cnt + 1'b1;
            end
        end
    end

`ifdef PRBS_CHK_BITCNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt <= '0;
        end else if (clr_cnt) begin
            bit_cnt <= '0;
        end else if (en && (state_q == CHECK) && (bit_cnt != '1)) begin
            bit_cnt <= bit_cnt + 1'b1;
        end
    end
`endif

endmodule
